// File: rtl/fc_seq_ctrl_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
// Holds the lane/byte geometry of one chunk, the bias word layout,
// the sequencer state encoding and the result packing helper.
package fc_seq_ctrl_pkg;

  localparam int FC_LANES  = 9;
  localparam int FC_BYTE_W = 8;
  localparam int FC_VEC_W  = FC_LANES * FC_BYTE_W;   // 72-bit packed chunk

  // Bias word packs two 16-bit biases as {b2, b1}: b1 occupies the low half.
  localparam int FC_BIAS_W    = 16;
  localparam int FC_BIAS_PK_W = 2 * FC_BIAS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_GAP,
    ST_DRAIN,
    ST_CAPTURE
  } fc_state_e;

  // Result word follows the same ordering as the bias word: {data2, data1}.
  function automatic logic [2*FC_BYTE_W-1:0] fc_pack_result(
    input logic [FC_BYTE_W-1:0] d1,
    input logic [FC_BYTE_W-1:0] d2
  );
    return {d2, d1};
  endfunction

endpackage

// File: rtl/fc_chunk_hold.sv
// Hold registers presented to the FC datapath.
// The datapath reads the chunk serially for several cycles after the strobe
// without latching it, so the vector and both weight vectors are kept here
// until the next chunk load. The bias is loaded separately when a run starts.
// Ports:
//   clk        clock
//   clr_i      synchronous clear of all hold registers (active-high)
//   vec_ld_i   load x/w1/w2 from the buffer read data
//   bias_ld_i  load the packed bias word
//   x_i, w1_i, w2_i, bias_i   values to load
//   x_o, w1_o, w2_o, bias_o   held values
module fc_chunk_hold
  import fc_seq_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    vec_ld_i,
  input  logic                    bias_ld_i,
  input  logic [FC_VEC_W-1:0]     x_i,
  input  logic [FC_VEC_W-1:0]     w1_i,
  input  logic [FC_VEC_W-1:0]     w2_i,
  input  logic [FC_BIAS_PK_W-1:0] bias_i,
  output logic [FC_VEC_W-1:0]     x_o,
  output logic [FC_VEC_W-1:0]     w1_o,
  output logic [FC_VEC_W-1:0]     w2_o,
  output logic [FC_BIAS_PK_W-1:0] bias_o
);

  logic [FC_VEC_W-1:0]     x_q, x_d;
  logic [FC_VEC_W-1:0]     w1_q, w1_d;
  logic [FC_VEC_W-1:0]     w2_q, w2_d;
  logic [FC_BIAS_PK_W-1:0] bias_q, bias_d;

  always_comb begin
    x_d    = x_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    bias_d = bias_q;
    if (vec_ld_i) begin
      x_d  = x_i;
      w1_d = w1_i;
      w2_d = w2_i;
    end
    if (bias_ld_i) begin
      bias_d = bias_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      x_q    <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      bias_q <= '0;
    end else begin
      x_q    <= x_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      bias_q <= bias_d;
    end
  end

  assign x_o    = x_q;
  assign w1_o   = w1_q;
  assign w2_o   = w2_q;
  assign bias_o = bias_q;

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the fully-connected layer datapath.
// On start it reads NUM_CHUNKS chunks from the feature/weight buffers, holds
// each one for the datapath and strobes fc_valid_o every CHUNK_PERIOD cycles,
// then waits for the datapath result and reports done or a drain timeout.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start_i, abort_i       run request (IDLE only) / cancel current run
//   bias_i                 packed {b2, b1}, latched on an accepted start
//   busy_o, done_o, err_o  status; done/err are single-cycle pulses
//   result_o               {data2, data1}, held until the next capture
//   rd_en_o, rd_addr_o     buffer read strobe and chunk index
//   x/w1/w2_rdata_i        buffer read data, RD_LAT cycles after rd_en_o
//   fc_valid_o, fc_*_o     chunk strobe and held chunk/bias to the datapath
//   fc_clear_n_o           one-cycle low pulse after an abort
//   fc_valid_i, fc_data*_i datapath result strobe and outputs
module fc_seq_ctrl
  import fc_seq_ctrl_pkg::*;
#(
  parameter int NUM_CHUNKS    = 32,
  parameter int CHUNK_PERIOD  = 13,
  parameter int RD_LAT        = 1,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [FC_BIAS_PK_W-1:0]       bias_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [2*FC_BYTE_W-1:0]        result_o,
  output logic                          rd_en_o,
  output logic [$clog2(NUM_CHUNKS)-1:0] rd_addr_o,
  input  logic [FC_VEC_W-1:0]           x_rdata_i,
  input  logic [FC_VEC_W-1:0]           w1_rdata_i,
  input  logic [FC_VEC_W-1:0]           w2_rdata_i,
  output logic                          fc_valid_o,
  output logic [FC_VEC_W-1:0]           fc_data_o,
  output logic [FC_VEC_W-1:0]           fc_weight1_o,
  output logic [FC_VEC_W-1:0]           fc_weight2_o,
  output logic [FC_BIAS_PK_W-1:0]       fc_bias_o,
  output logic                          fc_clear_n_o,
  input  logic                          fc_valid_i,
  input  logic [FC_BYTE_W-1:0]          fc_data1_i,
  input  logic [FC_BYTE_W-1:0]          fc_data2_i
);

  localparam int ADDR_W = $clog2(NUM_CHUNKS);
  // Cycles between ISSUE and the next FETCH so strobes land CHUNK_PERIOD apart:
  // one ISSUE, GAP_LEN gap cycles, one FETCH, RD_LAT wait cycles.
  localparam int GAP_LEN = CHUNK_PERIOD - RD_LAT - 2;

  fc_state_e state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic [2*FC_BYTE_W-1:0]   result_q, result_d;
  logic                     clear_n_q, clear_n_d;
  logic                     vec_ld, bias_ld;
  logic                     hold_clr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      k_q       <= '0;
      result_q  <= '0;
      clear_n_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      result_q  <= result_d;
      clear_n_q <= clear_n_d;
    end
  end

  // Next-state logic. cnt is shared: read-latency wait, gap timing,
  // drain timeout and the two capture cycles never overlap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    result_d  = result_q;
    clear_n_d = 1'b1;
    vec_ld    = 1'b0;
    bias_ld   = 1'b0;
    if (state_q != ST_IDLE && abort_i) begin
      state_d   = ST_IDLE;
      clear_n_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            bias_ld = 1'b1;
            k_d     = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // Read data is valid in the last wait cycle; capture it on this edge.
          if (cnt_q == 16'(RD_LAT - 1)) begin
            vec_ld  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_ISSUE: begin
          cnt_d = '0;
          if (k_q == ADDR_W'(NUM_CHUNKS - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = (GAP_LEN == 0) ? ST_FETCH : ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_q == 16'(GAP_LEN - 1)) state_d = ST_FETCH;
          else                           cnt_d   = cnt_q + 16'd1;
        end
        ST_DRAIN: begin
          // cnt counts cycles since the last ISSUE, minus one.
          if (fc_valid_i) begin
            cnt_d   = '0;
            state_d = ST_CAPTURE;
          end else if (cnt_q == 16'(DRAIN_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_CAPTURE: begin
          // First cycle: datapath outputs have settled, sample them.
          // Second cycle: announce the result.
          if (cnt_q == '0) begin
            result_d = fc_pack_result(fc_data1_i, fc_data2_i);
            cnt_d    = 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy_o     = (state_q != ST_IDLE);
    rd_en_o    = (state_q == ST_FETCH);
    fc_valid_o = (state_q == ST_ISSUE);
    done_o     = (state_q == ST_CAPTURE) && (cnt_q != '0) && !abort_i;
    err_o      = (state_q == ST_DRAIN) && !fc_valid_i && !abort_i &&
                 (cnt_q == 16'(DRAIN_TIMEOUT - 1));
  end

  assign rd_addr_o    = k_q;
  assign result_o     = result_q;
  assign fc_clear_n_o = clear_n_q;
  assign hold_clr     = ~rst_n;

  fc_chunk_hold u_hold (
    .clk       (clk),
    .clr_i     (hold_clr),
    .vec_ld_i  (vec_ld),
    .bias_ld_i (bias_ld),
    .x_i       (x_rdata_i),
    .w1_i      (w1_rdata_i),
    .w2_i      (w2_rdata_i),
    .bias_i    (bias_i),
    .x_o       (fc_data_o),
    .w1_o      (fc_weight1_o),
    .w2_o      (fc_weight2_o),
    .bias_o    (fc_bias_o)
  );

endmodule

// File: doc/fc_seq_ctrl.md
# fc_seq_ctrl

Sequencer for the fully-connected layer datapath. On `start_i`, it streams `NUM_CHUNKS` 9-byte input/weight chunks from the feature and weight buffers into the FC datapath, one `fc_valid_o` pulse every `CHUNK_PERIOD` cycles. It holds each chunk stable while the datapath consumes it serially, then captures the two rescaled 8-bit outputs and reports done or timeout. It sits between the layer-level control/buffers and the FC MAC datapath.

## Interface
Parameters:
- `NUM_CHUNKS`, 32: chunks per inference; must equal the datapath's chunk count.
- `CHUNK_PERIOD`, 13: cycles between successive `fc_valid_o` pulses; legal range ≥13 and ≥ `RD_LAT`+2.
- `RD_LAT`, 1: buffer read latency in cycles, `rd_en_o` to `*_rdata_i` valid; legal range ≥1.
- `DRAIN_TIMEOUT`, 16: cycles allowed from the last `fc_valid_o` to `fc_valid_i`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_i` in 1: one-cycle run request; honoured only in IDLE.
- `abort_i` in 1: cancel the current run.
- `bias_i` in 32: packed biases {b2[15:0], b1[15:0]}; latched on an accepted start.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the result is captured.
- `err_o` out 1: one-cycle pulse on drain timeout.
- `result_o` out 16: {data2, data1}; held until the next capture.
- `rd_en_o` out 1: buffer read strobe.
- `rd_addr_o` out $clog2(NUM_CHUNKS): chunk index.
- `x_rdata_i`, `w1_rdata_i`, `w2_rdata_i` in 72 each: nine signed int8 values, byte i at [8i+7:8i].
- `fc_valid_o` out 1: chunk-valid strobe to the datapath.
- `fc_data_o`, `fc_weight1_o`, `fc_weight2_o` out 72 each: held chunk.
- `fc_bias_o` out 32: latched bias.
- `fc_clear_n_o` out 1: active-low datapath clear; the system ANDs it into the datapath reset.
- `fc_valid_i` in 1: datapath output strobe.
- `fc_data1_i`, `fc_data2_i` in 8 each: datapath outputs.

## Operation
States:
- **IDLE**: `start_i` → latch `bias_i`, chunk index k=0, go to FETCH.
- **FETCH**: assert `rd_en_o` for 1 cycle with `rd_addr_o`=k, go to WAIT.
- **WAIT**: wait `RD_LAT` cycles. The `*_rdata_i` values are registered into the hold registers on the edge ending cycle rd+`RD_LAT`. Go to ISSUE.
- **ISSUE**: `fc_valid_o`=1 for exactly one cycle. If k=`NUM_CHUNKS`-1, go to DRAIN; else k++ and go to GAP.
- **GAP**: period counter runs until the next FETCH, so that consecutive `fc_valid_o` pulses are exactly `CHUNK_PERIOD` cycles apart.
- **DRAIN**: wait for `fc_valid_i`. It goes to CAPTURE, or to IDLE with `err_o` if `DRAIN_TIMEOUT` cycles elapse after ISSUE.
- **CAPTURE**: the datapath output registers update one cycle after `fc_valid_i`. Sample `fc_data1_i`/`fc_data2_i` in the cycle after `fc_valid_i`, write `result_o`, pulse `done_o`, go to IDLE.

Hold registers:
- The datapath does not latch the input vector; it reads it for 9 cycles after the strobe.
- `fc_data_o`, `fc_weight*_o` and `fc_bias_o` change only on a hold-register load.
- They are stable from each `fc_valid_o` cycle through the cycle before the next load, which is at least `CHUNK_PERIOD`-1 cycles.

Abort and start:
- `abort_i` in any non-IDLE state forces IDLE on the next edge with no `done_o` or `err_o`.
- On abort, `fc_clear_n_o`=0 for exactly one cycle to resynchronise the datapath's chunk counter.
- `abort_i` takes priority over every transition, including a simultaneous `fc_valid_i`.
- `start_i` while busy is ignored. `start_i` and `abort_i` together in IDLE: start accepted.
- `fc_valid_i` outside DRAIN is ignored.

## Timing
- Reset values: all outputs 0, except `fc_clear_n_o`=1. State IDLE, counters 0, hold registers 0.
- `rd_en_o` for chunk 0: cycle s+1, where s is the `start_i` cycle.
- `fc_valid_o` for chunk k: cycle s+`RD_LAT`+2+k·`CHUNK_PERIOD`.
- With the default datapath, `fc_valid_i` arrives 12 cycles after the last `fc_valid_o`. `done_o` follows 2 cycles after that; `result_o` is valid in the same cycle as `done_o`.
- `done_o` and `err_o` are mutually exclusive single-cycle pulses. IDLE is re-entered the cycle after either pulse.

## Structure
- Shared FC package holds `FC_LANES`=9, `FC_BYTE_W`=8, the packed-vector width (72), and the bias packing order. It also holds the state enum {IDLE, FETCH, WAIT, ISSUE, GAP, DRAIN, CAPTURE}.
- One natural sub-module: `fc_chunk_hold`, the three 72-bit hold registers plus bias, with load-enable and clear.

## Test plan
- **Defaults, buffer returns k in every byte:** 32 `fc_valid_o` pulses spaced exactly 13 cycles apart; `rd_addr_o` runs 0..31; `fc_data_o` = {9{k}} is stable for 12 cycles after each strobe.
- **Datapath model** drives `fc_valid_i` 12 cycles after the last strobe and data1=0x7F / data2=0x80 one cycle later → `result_o`=0x807F and a single `done_o` pulse.
- **`RD_LAT`=3, `CHUNK_PERIOD`=15:** first strobe at s+5, spacing 15, hold data correct.
- **No `fc_valid_i`:** `err_o` pulses `DRAIN_TIMEOUT` cycles after the last strobe, with no `done_o`; `result_o` is unchanged.
- **`abort_i` at chunk 10:** IDLE next cycle, a single 0 cycle on `fc_clear_n_o`, no `done_o`. A following start runs the full 32 chunks.
- **Disturbances:** `start_i` mid-run is ignored (still exactly 32 strobes). `rst_n` low mid-GAP gives all outputs at reset values on the next edge.
